// File: rtl/cache_line_refill.sv
// Cache miss refill engine: optional dirty-victim writeback, invalidate, fill, install.
// Control outputs decode from the state register, so a reset drops them immediately.
module cache_line_refill #(
    parameter int SET_W  = 3,
    parameter int WAY_W  = 2,
    parameter int TAG_W  = 5,
    parameter int OFF_W  = 2,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         miss_valid,
    output logic                         miss_ready,
    input  logic [SET_W-1:0]             miss_set,
    input  logic [TAG_W-1:0]             miss_tag,
    input  logic [WAY_W-1:0]             miss_way,
    input  logic [TAG_W-1:0]             victim_tag,
    input  logic                         victim_valid,
    input  logic                         victim_dirty,
    output logic                         tag_wr_en,
    output logic [SET_W-1:0]             tag_wr_set,
    output logic [WAY_W-1:0]             tag_wr_way,
    output logic [TAG_W-1:0]             tag_wr_tag,
    output logic                         tag_wr_valid,
    output logic                         tag_wr_dirty,
    output logic                         dat_rd_en,
    input  logic [DATA_W-1:0]            dat_rd_data,
    output logic                         dat_wr_en,
    output logic [SET_W-1:0]             dat_set,
    output logic [WAY_W-1:0]             dat_way,
    output logic [OFF_W-1:0]             dat_word,
    output logic [DATA_W-1:0]            dat_wr_data,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [TAG_W+SET_W+OFF_W-1:0] mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_ack,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         done,
    output logic [WAY_W-1:0]             done_way
);

    localparam logic [OFF_W-1:0] LAST_WORD = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_WB_RD, S_WB_REQ, S_INVAL, S_FILL_REQ, S_FILL_WR, S_INSTALL, S_DONE
    } state_t;

    state_t              state, state_next;
    logic [SET_W-1:0]    set_q;
    logic [TAG_W-1:0]    tag_q;
    logic [TAG_W-1:0]    vtag_q;
    logic [WAY_W-1:0]    way_q;
    logic [OFF_W-1:0]    cnt;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                rd_pend;
    logic                last;

    assign last = (cnt == LAST_WORD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_q   <= '0;
            tag_q   <= '0;
            vtag_q  <= '0;
            way_q   <= '0;
            cnt     <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= (state == S_WB_RD);
            case (state)
                S_IDLE: if (miss_valid) begin
                    set_q  <= miss_set;
                    tag_q  <= miss_tag;
                    vtag_q <= victim_tag;
                    way_q  <= miss_way;
                    cnt    <= '0;
                end
                S_WB_REQ: begin
                    if (rd_pend) wdata_q <= dat_rd_data;
                    if (mem_ack) cnt <= last ? '0 : cnt + 1'b1;
                end
                S_FILL_REQ: if (mem_ack) rdata_q <= mem_rdata;
                S_FILL_WR:  cnt <= last ? '0 : cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next   = state;
        miss_ready   = 1'b0;
        tag_wr_en    = 1'b0;
        tag_wr_set   = '0;
        tag_wr_way   = '0;
        tag_wr_tag   = '0;
        tag_wr_valid = 1'b0;
        tag_wr_dirty = 1'b0;
        dat_rd_en    = 1'b0;
        dat_wr_en    = 1'b0;
        dat_set      = '0;
        dat_way      = '0;
        dat_word     = '0;
        dat_wr_data  = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        done         = 1'b0;
        done_way     = '0;
        case (state)
            S_IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid)
                    state_next = (victim_valid && victim_dirty) ? S_WB_RD : S_INVAL;
            end
            S_WB_RD: begin
                dat_rd_en  = 1'b1;
                dat_set    = set_q;
                dat_way    = way_q;
                dat_word   = cnt;
                state_next = S_WB_REQ;
            end
            S_WB_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {vtag_q, set_q, cnt};
                // Read data arrives in the first cycle here; later cycles use the captured copy.
                mem_wdata = rd_pend ? dat_rd_data : wdata_q;
                if (mem_ack) state_next = last ? S_INVAL : S_WB_RD;
            end
            S_INVAL: begin
                tag_wr_en  = 1'b1;
                tag_wr_set = set_q;
                tag_wr_way = way_q;
                tag_wr_tag = tag_q;
                state_next = S_FILL_REQ;
            end
            S_FILL_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {tag_q, set_q, cnt};
                if (mem_ack) state_next = S_FILL_WR;
            end
            S_FILL_WR: begin
                dat_wr_en   = 1'b1;
                dat_set     = set_q;
                dat_way     = way_q;
                dat_word    = cnt;
                dat_wr_data = rdata_q;
                state_next  = last ? S_INSTALL : S_FILL_REQ;
            end
            S_INSTALL: begin
                tag_wr_en    = 1'b1;
                tag_wr_set   = set_q;
                tag_wr_way   = way_q;
                tag_wr_tag   = tag_q;
                tag_wr_valid = 1'b1;
                state_next   = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                done_way   = way_q;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule
